// File: rtl/gelu_pkg.sv
// Shared constants for the GELU inner-term datapath (Q8.16 fixed point).
package gelu_pkg;

    localparam int GELU_DATA_WIDTH = 24;
    localparam int GELU_FRAC_BITS  = 16;

    // 0.044715 and sqrt(2/pi) in Q8.16
    localparam logic signed [23:0] GELU_C1 = 24'sh000B72;
    localparam logic signed [23:0] GELU_C2 = 24'sh00CC42;

    // Saturation bounds for every stage result
    localparam logic signed [23:0] GELU_SAT_MAX = 24'sh7FFFFF;
    localparam logic signed [23:0] GELU_SAT_MIN = 24'sh800000;

endpackage

// File: rtl/gelu_x_align_fifo.sv
// In-order FIFO that holds raw x samples until the matching x^3 arrives.
// Reading while empty returns zero; error pulses report drop/underflow.
module gelu_x_align_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic signed [WIDTH-1:0]    din,
    input  logic                       pop,
    output logic signed [WIDTH-1:0]    dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full FIFO only succeeds when a pop frees a slot the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign ovf_err = push && full && !pop;
    assign unf_err = pop && empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gelu_inner_combiner.sv
// Computes u = sqrt(2/pi) * (x + 0.044715 * x^3) in Q8.16 over three
// pipeline stages, re-aligning raw x with the late-arriving x^3.
module gelu_inner_combiner
    import gelu_pkg::*;
#(
    parameter int DATA_WIDTH = GELU_DATA_WIDTH,
    parameter int FRAC_BITS  = GELU_FRAC_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    input  logic                          x_valid,
    input  logic signed [DATA_WIDTH-1:0]  x3_in,
    input  logic                          x3_valid,
    input  logic                          x3_ovf,
    input  logic                          clr_err,
    output logic signed [DATA_WIDTH-1:0]  u_out,
    output logic                          u_valid,
    output logic                          u_ovf,
    output logic                          align_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0]         C1_W   = PW'(GELU_C1);
    localparam logic signed [PW-1:0]         C2_W   = PW'(GELU_C2);
    localparam logic signed [PW-1:0]         SAT_HI = PW'(GELU_SAT_MAX);
    localparam logic signed [PW-1:0]         SAT_LO = PW'(GELU_SAT_MIN);
    localparam logic [DATA_WIDTH-1:0]        SAT_HI_D = DATA_WIDTH'(GELU_SAT_MAX);
    localparam logic [DATA_WIDTH-1:0]        SAT_LO_D = DATA_WIDTH'(GELU_SAT_MIN);
    localparam logic signed [PW-1:0]         RND    = PW'(1) << (FRAC_BITS - 1);

    // Round half up, then drop the fractional bits of the product
    function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] v);
        return (v + RND) >>> FRAC_BITS;
    endfunction

    // Clamp to the sample range; MSB of the result flags a clamp
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [PW-1:0] v);
        if (v > SAT_HI) return {1'b1, SAT_HI_D};
        if (v < SAT_LO) return {1'b1, SAT_LO_D};
        return {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    logic signed [DATA_WIDTH-1:0] fifo_dout;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_ovf_err;
    logic                         fifo_unf_err;

    gelu_x_align_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (x_valid),
        .din     (x_in),
        .pop     (x3_valid),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .ovf_err (fifo_ovf_err),
        .unf_err (fifo_unf_err)
    );

    logic signed [DATA_WIDTH-1:0] x_p1;
    logic signed [DATA_WIDTH-1:0] p1_p1;
    logic                         ovf_p1;
    logic                         vld_p1;
    logic signed [DATA_WIDTH-1:0] s_p2;
    logic                         ovf_p2;
    logic                         vld_p2;
    logic [DATA_WIDTH:0]          s1_res;
    logic [DATA_WIDTH:0]          s2_res;
    logic [DATA_WIDTH:0]          s3_res;

    // Combinational arithmetic feeding each stage register
    always_comb begin
        s1_res = saturate(round_shift(PW'(x3_in) * C1_W));
        s2_res = saturate(PW'(x_p1) + PW'(p1_p1));
        s3_res = saturate(round_shift(PW'(s_p2) * C2_W));
    end

    // ---- Stage 1: p1 = x3 * C1, paired with the popped x ----
    always_ff @(posedge clk) begin
        if (x3_valid) begin
            x_p1   <= fifo_dout;
            p1_p1  <= s1_res[DATA_WIDTH-1:0];
            ovf_p1 <= x3_ovf | s1_res[DATA_WIDTH];
        end
    end

    // ---- Stage 2: s = x + p1 ----
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            s_p2   <= s2_res[DATA_WIDTH-1:0];
            ovf_p2 <= ovf_p1 | s2_res[DATA_WIDTH];
        end
    end

    // Valid tokens travelling alongside the stage data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= x3_valid;
            vld_p2 <= vld_p1;
        end
    end

    // ---- Stage 3: u = s * C2, held between results ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_out   <= '0;
            u_ovf   <= 1'b0;
            u_valid <= 1'b0;
        end else begin
            u_valid <= vld_p2;
            if (vld_p2) begin
                u_out <= s3_res[DATA_WIDTH-1:0];
                u_ovf <= ovf_p2 | s3_res[DATA_WIDTH];
            end
        end
    end

    // Sticky alignment error; a fresh error outranks a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (fifo_ovf_err || fifo_unf_err) begin
            align_err <= 1'b1;
        end else if (clr_err) begin
            align_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gelu_inner_combiner.sv
// Directed-vector bench for gelu_inner_combiner with a queue scoreboard.
module tb_gelu_inner_combiner;

    localparam int DW = 24;
    localparam int LW = 3;

    localparam logic [DW-1:0] ONE     = 24'h010000;
    localparam logic [DW-1:0] NEG_ONE = 24'hFF0000;
    localparam logic [DW-1:0] MAXP    = 24'h7FFFFF;
    localparam logic [DW-1:0] U_ONE   = 24'h00D564;
    localparam logic [DW-1:0] U_NEG   = 24'hFF2A9C;
    localparam logic [DW-1:0] U_MAXP  = 24'h6620FF;
    localparam logic [DW-1:0] U_X0_X1 = 24'h000922;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] x_in = '0;
    logic          x_valid = 1'b0;
    logic [DW-1:0] x3_in = '0;
    logic          x3_valid = 1'b0;
    logic          x3_ovf = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] u_out;
    logic          u_valid;
    logic          u_ovf;
    logic          align_err;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    gelu_inner_combiner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_in       (x_in),
        .x_valid    (x_valid),
        .x3_in      (x3_in),
        .x3_valid   (x3_valid),
        .x3_ovf     (x3_ovf),
        .clr_err    (clr_err),
        .u_out      (u_out),
        .u_valid    (u_valid),
        .u_ovf      (u_ovf),
        .align_err  (align_err),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic [DW-1:0] u;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every result must match the oldest expectation, on time
    always @(negedge clk) begin
        if (rst_n && u_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_u_valid: got u_out=%h, required no output", u_out);
            end else begin
                mon_e = sb.pop_front();
                chk("u_out", u_out, mon_e.u);
                chk("u_ovf", u_ovf, mon_e.ovf);
                chk("u_valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // One clock of stimulus; an x3 strobe queues its expected result
    task automatic drive(input logic xv, input logic [DW-1:0] x,
                         input logic yv, input logic [DW-1:0] y, input logic yo,
                         input logic clr, input logic [DW-1:0] eu, input logic eo);
        x_valid  = xv;
        x_in     = x;
        x3_valid = yv;
        x3_in    = y;
        x3_ovf   = yo;
        clr_err  = clr;
        if (yv) sb.push_back('{eu, eo, cyc + 3});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_u_out"}, u_out, 0);
        chk({tag, "_u_valid"}, u_valid, 0);
        chk({tag, "_u_ovf"}, u_ovf, 0);
        chk({tag, "_align_err"}, align_err, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk_outputs_zero("reset");
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // x = 1.0 with x^3 two cycles later
        drive(1'b1, ONE, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        idle(1);
        drive(1'b0, '0, 1'b1, ONE, 1'b0, 1'b0, U_ONE, 1'b0);
        idle(4);

        // x = -1.0
        drive(1'b1, NEG_ONE, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        idle(1);
        drive(1'b0, '0, 1'b1, NEG_ONE, 1'b0, 1'b0, U_NEG, 1'b0);
        idle(4);

        // zero stream, 2-cycle skew, level bounded by the skew
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, '0, i >= 2, '0, 1'b0, 1'b0, '0, 1'b0);
            chk("fifo_level_le2", fifo_level <= 2, 1);
        end
        idle(4);

        // stage-2 saturation, then upstream overflow on a normal sample
        drive(1'b1, MAXP, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, MAXP, 1'b0, 1'b0, U_MAXP, 1'b1);
        drive(1'b1, ONE, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, ONE, 1'b1, 1'b0, U_ONE, 1'b1);
        idle(4);
        chk("align_err_clean", align_err, 0);

        // overfill: fifth push dropped
        for (int i = 0; i < 5; i++) drive(1'b1, ONE, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("full_level", fifo_level, 4);
        chk("overflow_err", align_err, 1);
        // push+pop while full keeps level
        drive(1'b1, ONE, 1'b1, ONE, 1'b0, 1'b0, U_ONE, 1'b0);
        chk("full_pushpop_level", fifo_level, 4);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, ONE, 1'b0, 1'b0, U_ONE, 1'b0);
        chk("drained_level", fifo_level, 0);
        // underflow: x taken as zero
        drive(1'b0, '0, 1'b1, ONE, 1'b0, 1'b0, U_X0_X1, 1'b0);
        idle(4);
        chk("sticky_err", align_err, 1);
        // clear coinciding with a new underflow keeps the flag
        drive(1'b0, '0, 1'b1, '0, 1'b0, 1'b1, '0, 1'b0);
        chk("clr_vs_new_err", align_err, 1);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        chk("clr_err", align_err, 0);
        idle(4);

        // reset while results are in flight
        for (int i = 0; i < 6; i++) drive(1'b1, ONE, i >= 1, ONE, 1'b0, 1'b0, U_ONE, 1'b0);
        chk("pre_reset_u_out", u_out, U_ONE);
        x_valid  = 1'b0;
        x3_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_outputs_zero("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        chk("post_reset_level", fifo_level, 0);
        chk("post_reset_u_out", u_out, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gelu_inner_combiner.md
GELU_INNER_COMBINER -- requirements
Module: gelu_inner_combiner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: sample width, signed two's complement.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits (Q8.16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: x alignment FIFO depth, power of two.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port x_in  in  DATA_WIDTH  raw x sample, same value and strobe as the cubic calculator's input.
REQ-007 SHALL have port x_valid  in  1  x_in qualifier.
REQ-008 SHALL have port x3_in  in  DATA_WIDTH  x^3 from the cubic calculator.
REQ-009 SHALL have port x3_valid  in  1  x3_in qualifier.
REQ-010 SHALL have port x3_ovf  in  1  cubic calculator overflow flag for x3_in.
REQ-011 SHALL have port clr_err  in  1  synchronous clear of align_err.
REQ-012 SHALL have port u_out  out  DATA_WIDTH  u = sqrt(2/pi)*(x + 0.044715*x^3), Q8.16.
REQ-013 SHALL have port u_valid  out  1  u_out qualifier, one-cycle pulse per result.
REQ-014 SHALL have port u_ovf  out  1  overflow for the u_out sample, valid with u_valid.
REQ-015 SHALL have port align_err  out  1  sticky FIFO overflow/underflow flag.
REQ-016 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL push x_in into an in-order FIFO on each cycle x_valid=1, and pop one entry on each cycle x3_valid=1, pairing popped x with x3_in.
REQ-018 SHALL, on push while full and no pop, drop x_in and set align_err; push+pop while full SHALL succeed with level unchanged.
REQ-019 SHALL, on pop while empty (including with simultaneous push), use x=0 for that sample, set align_err, and still perform the push.
REQ-020 SHALL compute in a 3-stage pipeline: S1 p1 = x3*C1; S2 s = x + p1; S3 u = s*C2.
REQ-021 SHALL use C1 = 24'h000B72 (2930, 0.044715) and C2 = 24'h00CC42 (52290, sqrt(2/pi)).
REQ-022 SHALL form products at 2*DATA_WIDTH signed, add 2^(FRAC_BITS-1), arithmetic right shift FRAC_BITS (round half up).
REQ-023 SHALL saturate each stage result to [-2^23, 2^23-1]; any saturation marks the sample overflowed.
REQ-024 SHALL set u_ovf = x3_ovf OR any stage saturation, propagated with its sample.
REQ-025 SHALL assert u_valid exactly 3 cycles after the accepting x3_valid edge; fully pipelined, one result per cycle, no backpressure.
REQ-026 SHALL hold u_out and u_ovf at last value when u_valid=0.
REQ-027 SHALL clear align_err when clr_err=1; a same-cycle new error SHALL win (flag stays 1).

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear u_out=0, u_valid=0, u_ovf=0, align_err=0, fifo_level=0, FIFO pointers and all pipeline valids.
REQ-029 SHALL discard in-flight samples on reset mid-operation; no u_valid for them after release.

Structure
REQ-030 SHALL take DATA_WIDTH/FRAC_BITS defaults, C1, C2 and the saturation bounds from the shared package gelu_pkg.
REQ-031 SHALL implement the FIFO as sub-module gelu_x_align_fifo (push, pop, data, full, empty, level, err pulses).

Verification
REQ-032 SHALL test x=1.0 (24'h010000), x3=24'h010000 two cycles later -> u_out=24'h00D564, u_ovf=0, 3 cycles after x3_valid.
REQ-033 SHALL test x=-1.0 (24'hFF0000), x3=24'hFF0000 -> u_out=24'hFF2A9C, u_ovf=0.
REQ-034 SHALL test x=0, x3=0 back-to-back for 8 cycles with 2-cycle skew -> 8 consecutive u_valid, u_out=0, fifo_level never >2.
REQ-035 SHALL test x=24'h7FFFFF, x3=24'h7FFFFF -> S2 saturates, u_ovf=1; and x3_ovf=1 on a normal sample -> u_ovf=1.
REQ-036 SHALL test 5 x_valid with no x3_valid -> fifo_level=4, align_err=1; then x3_valid on empty after drain -> align_err stays 1 until clr_err.
REQ-037 SHALL test rst_n low mid-stream -> all outputs 0 immediately, no stale u_valid after release.
